// File: rtl/product_accumulator.sv
// ----------------------------------------------------------------------------
// product_accumulator
//
// Purpose:
//    Accumulate half of a multiply-accumulate path. Takes unsigned products
//    from the carry-save multiplier over a valid/ready handshake, sums a
//    fixed-length frame of COUNT products and presents the frame sum on a
//    held valid/ready output. A sticky flag records any carry out of the
//    accumulator during the frame.
//
// Optional feature:
//    SATURATE_EN  when defined, the accumulator clamps to 2^ACC_W-1 on the
//                 first carry-out and stays clamped for the rest of the
//                 frame. When undefined the sum wraps modulo 2^ACC_W.
//
// Parameters:
//    PROD_W  width of an incoming product
//    ACC_W   accumulator / out_sum width (>= PROD_W)
//    COUNT   products per frame (>= 1)
//
// Ports:
//    clk           rising-edge clock
//    rst_n         asynchronous active-low reset
//    clear         synchronous abort of the partial frame and any pending result
//    in_valid      in_prod is valid this cycle
//    in_ready      block can accept a product this cycle
//    in_prod       unsigned product
//    out_valid     out_sum/out_overflow valid, held until accepted
//    out_ready     consumer accepts the result
//    out_sum       frame sum (reads 0 while idle)
//    out_overflow  sum exceeded 2^ACC_W-1 during the frame
//    busy          a frame is in progress or a result is pending
// ----------------------------------------------------------------------------
module product_accumulator #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 12,
   parameter int COUNT  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_overflow,
   output logic              busy
);

   localparam int CNT_W = $clog2(COUNT + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             ovf;
   logic             ovf_next;

   logic [ACC_W:0]   sum_wide;
   logic             carry;
   logic [ACC_W-1:0] sum_fin;

   // The add is one bit wider than the accumulator so the carry-out is
   // available as the overflow indication. acc is always zero in IDLE, so the
   // same adder serves both the first and the following products of a frame.
   assign sum_wide = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
   assign carry    = sum_wide[ACC_W];

`ifdef SATURATE_EN
   // Once the frame has overflowed the accumulator stays pinned at full scale,
   // so the sticky flag doubles as the "already clamped" indication.
   assign sum_fin = (carry || ovf) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
   assign sum_fin = sum_wide[ACC_W-1:0];
`endif

   // State, accumulator, counter and overflow flag all update together; the
   // outputs are decoded straight from these registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         cnt   <= cnt_next;
         ovf   <= ovf_next;
      end
   end

   // Next-state and datapath selection. clear wins over every handshake,
   // including a result being accepted in the same cycle. In IDLE and ACCUM
   // in_ready is high, so in_valid alone marks a transfer there.
   always_comb begin
      state_next = state;
      acc_next   = acc;
      cnt_next   = cnt;
      ovf_next   = ovf;
      if (clear) begin
         state_next = IDLE;
         acc_next   = '0;
         cnt_next   = '0;
         ovf_next   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc_next   = sum_fin;
                  cnt_next   = CNT_W'(1);
                  ovf_next   = carry;
                  state_next = (COUNT > 1) ? ACCUM : HOLD;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  acc_next = sum_fin;
                  cnt_next = cnt + CNT_W'(1);
                  ovf_next = ovf | carry;
                  if (cnt == LAST_CNT) begin
                     state_next = HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_next = IDLE;
                  acc_next   = '0;
                  cnt_next   = '0;
                  ovf_next   = 1'b0;
               end
            end
            default: begin
               state_next = IDLE;
               acc_next   = '0;
               cnt_next   = '0;
               ovf_next   = 1'b0;
            end
         endcase
      end
   end

   assign in_ready     = (state != HOLD);
   assign out_valid    = (state == HOLD);
   assign busy         = (state != IDLE);
   assign out_sum      = acc;
   assign out_overflow = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// ----------------------------------------------------------------------------
// tb_product_accumulator
//
// Drives three accumulator instances (COUNT=4/ACC_W=12, COUNT=4/ACC_W=9 and
// COUNT=1/ACC_W=9) from a shared input stream. A frame-level reference model
// keeps the products of the open frame per instance; when a frame completes
// its expected sum and overflow flag are pushed into a queue. A monitor on the
// falling edge compares the handshake/status outputs against the model and
// pops the expected result when the consumer accepts it.
// ----------------------------------------------------------------------------
module tb_product_accumulator;

   localparam int NDUT = 3;
   localparam int COUNTS [NDUT] = '{4, 4, 1};
   localparam int ACCWS  [NDUT] = '{12, 9, 9};

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       inValid;
   logic [7:0] inProd;
   logic       outReady;

   logic [NDUT-1:0] inReadyVec;
   logic [NDUT-1:0] outValidVec;
   logic [NDUT-1:0] outOvfVec;
   logic [NDUT-1:0] busyVec;
   logic [11:0]     sum0;
   logic [8:0]      sum1;
   logic [8:0]      sum2;

   typedef struct {
      int inst;
      int sum;
      bit ovf;
   } exp_t;

   exp_t expQ[$];

   int frameCnt [NDUT];
   int frameSum [NDUT];
   bit holding  [NDUT];

   int checks   = 0;
   int failures = 0;

   product_accumulator #(.PROD_W(8), .ACC_W(12), .COUNT(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(inValid), .in_ready(inReadyVec[0]), .in_prod(inProd),
      .out_valid(outValidVec[0]), .out_ready(outReady), .out_sum(sum0),
      .out_overflow(outOvfVec[0]), .busy(busyVec[0])
   );

   product_accumulator #(.PROD_W(8), .ACC_W(9), .COUNT(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(inValid), .in_ready(inReadyVec[1]), .in_prod(inProd),
      .out_valid(outValidVec[1]), .out_ready(outReady), .out_sum(sum1),
      .out_overflow(outOvfVec[1]), .busy(busyVec[1])
   );

   product_accumulator #(.PROD_W(8), .ACC_W(9), .COUNT(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(inValid), .in_ready(inReadyVec[2]), .in_prod(inProd),
      .out_valid(outValidVec[2]), .out_ready(outReady), .out_sum(sum2),
      .out_overflow(outOvfVec[2]), .busy(busyVec[2])
   );

   // 10-unit clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int sumOf(int k);
      case (k)
         0:       return int'(sum0);
         1:       return int'(sum1);
         default: return int'(sum2);
      endcase
   endfunction

   task automatic checkOutput(string name, int k, int got, int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("[TB] FAIL %s dut%0d got=%0d expected=%0d at %0t", name, k, got, exp, $time);
      end
   endtask

   function automatic int findExp(int k);
      foreach (expQ[i]) begin
         if (expQ[i].inst == k) return i;
      end
      return -1;
   endfunction

   // Frame result from plain arithmetic on the whole frame total: partial sums
   // only grow, so the frame overflowed exactly when the total exceeds full scale.
   task automatic pushExp(int k, int total);
      exp_t e;
      int   maxv;
      maxv  = (1 << ACCWS[k]) - 1;
      e.inst = k;
      e.ovf  = (total > maxv);
`ifdef SATURATE_EN
      e.sum  = e.ovf ? maxv : total;
`else
      e.sum  = total % (maxv + 1);
`endif
      expQ.push_back(e);
   endtask

   task automatic dropExp(int k);
      int idx;
      idx = findExp(k);
      if (idx >= 0) expQ.delete(idx);
   endtask

   task automatic modelReset();
      for (int k = 0; k < NDUT; k++) begin
         frameCnt[k] = 0;
         frameSum[k] = 0;
         holding[k]  = 1'b0;
      end
      expQ.delete();
   endtask

   // Advance the model by one clock edge using the inputs that edge sampled.
   task automatic modelStep();
      for (int k = 0; k < NDUT; k++) begin
         if (clear) begin
            frameCnt[k] = 0;
            frameSum[k] = 0;
            holding[k]  = 1'b0;
            dropExp(k);
         end else if (holding[k]) begin
            if (outReady) holding[k] = 1'b0;
         end else if (inValid) begin
            frameSum[k] += int'(inProd);
            frameCnt[k]++;
            if (frameCnt[k] == COUNTS[k]) begin
               pushExp(k, frameSum[k]);
               holding[k]  = 1'b1;
               frameCnt[k] = 0;
               frameSum[k] = 0;
            end
         end
      end
   endtask

   // One cycle of stimulus: drive just after a rising edge, step the model at
   // the next rising edge.
   task automatic applyStimulus(bit c, bit v, int p, bit r);
      clear    = c;
      inValid  = v;
      inProd   = 8'(p);
      outReady = r;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic idleCycles(int n, bit r);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, $urandom_range(255), r);
   endtask

   // Monitor: status outputs against the model every cycle, frame result
   // against the scoreboard while held, popped when the consumer accepts it.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < NDUT; k++) begin
            int idx;
            checkOutput("out_valid", k, int'(outValidVec[k]), int'(holding[k]));
            checkOutput("in_ready", k, int'(inReadyVec[k]), int'(!holding[k]));
            checkOutput("busy", k, int'(busyVec[k]), int'(holding[k] || frameCnt[k] > 0));
            if (!busyVec[k]) checkOutput("idle_sum", k, sumOf(k), 0);
            if (outValidVec[k]) begin
               idx = findExp(k);
               if (idx < 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_result dut%0d got_sum=%0d expected=none at %0t", k, sumOf(k), $time);
               end else begin
                  checkOutput("out_sum", k, sumOf(k), expQ[idx].sum);
                  checkOutput("out_overflow", k, int'(outOvfVec[k]), int'(expQ[idx].ovf));
                  if (outReady && !clear) expQ.delete(idx);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int prods [4];
      prods = '{30, 35, 27, 225};

      rst_n    = 1'b0;
      clear    = 1'b0;
      inValid  = 1'b0;
      inProd   = 8'd0;
      outReady = 1'b0;
      modelReset();
      #3;
      for (int k = 0; k < NDUT; k++) begin
         checkOutput("reset_out_valid", k, int'(outValidVec[k]), 0);
         checkOutput("reset_busy", k, int'(busyVec[k]), 0);
         checkOutput("reset_in_ready", k, int'(inReadyVec[k]), 1);
         checkOutput("reset_sum", k, sumOf(k), 0);
         checkOutput("reset_ovf", k, int'(outOvfVec[k]), 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic frame, back-to-back with the consumer always ready
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, prods[i], 1'b1);
      idleCycles(3, 1'b1);

      // Gaps between products and a stalled consumer
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, prods[i], 1'b0);
         idleCycles(2, 1'b0);
      end
      idleCycles(5, 1'b0);
      idleCycles(3, 1'b1);

      // Overflow: 4 x 225 = 900 exceeds 9-bit full scale
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 225, 1'b1);
      idleCycles(2, 1'b1);

      // clear mid-frame drops the product offered in the same cycle
      applyStimulus(1'b0, 1'b1, 30, 1'b1);
      applyStimulus(1'b0, 1'b1, 35, 1'b1);
      applyStimulus(1'b1, 1'b1, 27, 1'b1);
      for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, i, 1'b1);
      idleCycles(2, 1'b1);

      // clear while a result is pending and the consumer is ready
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, prods[i], 1'b0);
      idleCycles(1, 1'b0);
      applyStimulus(1'b1, 1'b0, 0, 1'b1);
      idleCycles(3, 1'b1);

      // Asynchronous reset between edges in the middle of a frame
      applyStimulus(1'b0, 1'b1, 30, 1'b1);
      applyStimulus(1'b0, 1'b1, 35, 1'b1);
      clear   = 1'b0;
      inValid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      modelReset();
      for (int k = 0; k < NDUT; k++) begin
         checkOutput("async_out_valid", k, int'(outValidVec[k]), 0);
         checkOutput("async_busy", k, int'(busyVec[k]), 0);
         checkOutput("async_sum", k, sumOf(k), 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b1, 225, 1'b1);
      idleCycles(2, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         applyStimulus($urandom_range(99) < 3, $urandom_range(99) < 70,
                       $urandom_range(255), $urandom_range(99) < 60);
      end

      // Drain: every held result must have been delivered
      idleCycles(4, 1'b1);
      checkOutput("drain_pending", 0, expQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
